wshb_mire_writer: RTL and testbench

//  Wishbone master that writes a test pattern (8 colour bars + 16-px grid) into
//  the SDRAM framebuffer. Drives the mire-side slave port of the Wishbone

---
 rtl/wshb_mire_writer_pkg.sv | 36 +++
 rtl/wshb_mire_writer_pixel_gen.sv | 92 +++++++++
 rtl/wshb_mire_writer.sv | 123 ++++++++++++
 tb/tb_wshb_mire_writer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wshb_mire_writer_pkg.sv
// Shared constants and types for the mire (test pattern) framebuffer writer.
// Holds the default video geometry, the RGB565 colour-bar palette, the writer FSM states and the pixel colour function.
package wshb_mire_writer_pkg;

  localparam int unsigned HDISP_DEF     = 800;
  localparam int unsigned VDISP_DEF     = 480;
  localparam int unsigned BURST_DEF     = 64;
  localparam int unsigned PAUSE_CYC_DEF = 4;
  localparam logic [31:0] BASE_ADR_DEF  = 32'h0000_0000;

  localparam logic [15:0] GRID_COLOR = 16'hFFFF;
  localparam logic [15:0] BAR_COLORS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2
  } mire_state_t;

  // Grid lines every 16 pixels in both directions take priority over the bars.
  function automatic logic [15:0] mire_pixel(input logic [3:0] x_lsb,
                                             input logic [3:0] y_lsb,
                                             input logic [2:0] bar);
    logic [15:0] color;
    if ((x_lsb == 4'd0) || (y_lsb == 4'd0)) begin
      color = GRID_COLOR;
    end else begin
      color = BAR_COLORS[bar];
    end
    return color;
  endfunction

endpackage

// File: rtl/wshb_mire_writer_pixel_gen.sv
// Pixel walker for the mire writer: tracks x/y/bar position and produces the
// registered write address and RGB565 data for the current pixel.
module wshb_mire_writer_pixel_gen
  import wshb_mire_writer_pkg::*;
#(
  parameter int unsigned HDISP    = HDISP_DEF,
  parameter int unsigned VDISP    = VDISP_DEF,
  parameter logic [31:0] BASE_ADR = BASE_ADR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic        last_pixel_o,
  output logic [31:0] adr_o,
  output logic [15:0] dat_o
);

  localparam int unsigned XW    = ($clog2(HDISP) > 4) ? $clog2(HDISP) : 4;
  localparam int unsigned YW    = ($clog2(VDISP) > 4) ? $clog2(VDISP) : 4;
  localparam int unsigned BAR_W = HDISP / 8;
  localparam int unsigned SW    = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    bar_q, bar_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [31:0]   adr_q, adr_d;
  logic [15:0]   dat_q, dat_d;
  logic          last_x_s;
  logic          last_y_s;

  assign last_x_s     = (x_q == XW'(HDISP - 1));
  assign last_y_s     = (y_q == YW'(VDISP - 1));
  assign last_pixel_o = last_x_s && last_y_s;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;

  // Next pixel position; bar index follows x through a sub-counter instead of a divide.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    bar_d = bar_q;
    sub_d = sub_q;
    adr_d = adr_q;
    if (step_i) begin
      if (last_x_s) begin
        x_d   = '0;
        bar_d = 3'd0;
        sub_d = '0;
        if (last_y_s) begin
          y_d   = '0;
          adr_d = BASE_ADR;
        end else begin
          y_d   = y_q + YW'(1);
          adr_d = adr_q + 32'd2;
        end
      end else begin
        x_d   = x_q + XW'(1);
        adr_d = adr_q + 32'd2;
        if (sub_q == SW'(BAR_W - 1)) begin
          sub_d = '0;
          bar_d = bar_q + 3'd1;
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end
    end else begin
      adr_d = adr_q;
    end
    dat_d = mire_pixel(x_d[3:0], y_d[3:0], bar_d);
  end

  // Position, address and data registers; address/data only move on an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      bar_q <= 3'd0;
      sub_q <= '0;
      adr_q <= BASE_ADR;
      dat_q <= GRID_COLOR;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      bar_q <= bar_d;
      sub_q <= sub_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/wshb_mire_writer.sv
// Wishbone master writing the colour-bar/grid test pattern into the framebuffer,
// releasing the bus every BURST writes so the VGA reader can be granted.
module wshb_mire_writer
  import wshb_mire_writer_pkg::*;
#(
  parameter int unsigned HDISP     = HDISP_DEF,
  parameter int unsigned VDISP     = VDISP_DEF,
  parameter logic [31:0] BASE_ADR  = BASE_ADR_DEF,
  parameter int unsigned BURST     = BURST_DEF,
  parameter int unsigned PAUSE_CYC = PAUSE_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  output logic        frame_done_o,
  output logic        wshb_cyc_o,
  output logic        wshb_stb_o,
  output logic        wshb_we_o,
  output logic [31:0] wshb_adr_o,
  output logic [15:0] wshb_dat_ms_o,
  output logic [1:0]  wshb_sel_o,
  output logic [2:0]  wshb_cti_o,
  output logic [1:0]  wshb_bte_o,
  input  logic        wshb_ack_i
);

  localparam int unsigned BW = ($clog2(BURST) > 1) ? $clog2(BURST) : 1;
  localparam int unsigned PW = ($clog2(PAUSE_CYC) > 1) ? $clog2(PAUSE_CYC) : 1;

  mire_state_t   state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [PW-1:0] pause_cnt_q, pause_cnt_d;
  logic          cyc_q, cyc_d;
  logic          step_s;
  logic          last_pixel_s;

  assign step_s = (state_q == WRITE) && wshb_ack_i;

  wshb_mire_writer_pixel_gen #(
    .HDISP    (HDISP),
    .VDISP    (VDISP),
    .BASE_ADR (BASE_ADR)
  ) u_pixel_gen (
    .clk          (clk),
    .rst          (rst),
    .step_i       (step_s),
    .last_pixel_o (last_pixel_s),
    .adr_o        (wshb_adr_o),
    .dat_o        (wshb_dat_ms_o)
  );

  // Bus tenure sequencing: burst/pause accounting and frame-end enable sampling.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    pause_cnt_d = pause_cnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        pause_cnt_d = '0;
        if (enable_i) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (wshb_ack_i) begin
          if (last_pixel_s) begin
            burst_cnt_d = '0;
            state_d     = enable_i ? PAUSE : IDLE;
          end else if (burst_cnt_q == BW'(BURST - 1)) begin
            burst_cnt_d = '0;
            state_d     = PAUSE;
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end else begin
          state_d = WRITE;
        end
      end
      PAUSE: begin
        if (pause_cnt_q == PW'(PAUSE_CYC - 1)) begin
          pause_cnt_d = '0;
          state_d     = WRITE;
        end else begin
          pause_cnt_d = pause_cnt_q + PW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
        pause_cnt_d = '0;
      end
    endcase
    cyc_d = (state_d == WRITE);
  end

  // State and counters; cyc is registered from the next state so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      pause_cnt_q <= '0;
      cyc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      pause_cnt_q <= pause_cnt_d;
      cyc_q       <= cyc_d;
    end
  end

  // frame_done marks the very cycle the last pixel of the frame is accepted.
  assign frame_done_o = step_s && last_pixel_s;
  assign wshb_cyc_o   = cyc_q;
  assign wshb_stb_o   = cyc_q;
  assign wshb_we_o    = 1'b1;
  assign wshb_sel_o   = 2'b11;
  assign wshb_cti_o   = 3'b000;
  assign wshb_bte_o   = 2'b00;

endmodule

// File: tb/tb_wshb_mire_writer.sv
// Randomised self-checking bench for wshb_mire_writer against a frame-level
// reference model (pixel index, tenure length, pause length).
module tb_wshb_mire_writer;

  localparam int          H     = 16;
  localparam int          V     = 2;
  localparam int          BURST = 8;
  localparam int          PAUSE = 2;
  localparam logic [31:0] BASE  = 32'h100;
  localparam int          FRAME = H * V;
  localparam logic [15:0] COLORS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic        frame_done_o;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [15:0] dat;
  logic [1:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: next pixel index to write, acks in this tenure,
  // idle cycles still owed between tenures, and whether the writer is parked.
  int n, tacks, gap, fd_count, cyc_no;
  bit idle;

  wshb_mire_writer #(
    .HDISP(H), .VDISP(V), .BASE_ADR(BASE), .BURST(BURST), .PAUSE_CYC(PAUSE)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .frame_done_o(frame_done_o),
    .wshb_cyc_o(cyc), .wshb_stb_o(stb), .wshb_we_o(we), .wshb_adr_o(adr),
    .wshb_dat_ms_o(dat), .wshb_sel_o(sel), .wshb_cti_o(cti), .wshb_bte_o(bte),
    .wshb_ack_i(ack_i)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_pixel(input int idx);
    int x, y;
    x = idx % H;
    y = idx / H;
    if ((x % 16 == 0) || (y % 16 == 0)) return 16'hFFFF;
    return COLORS[x / (H / 8)];
  endfunction

  task automatic model_reset();
    n = 0; tacks = 0; gap = 0; idle = 1'b1; fd_count = 0;
  endtask

  // One bus cycle: choose ack, compare DUT against the model, advance the model.
  task automatic step(input int mode);
    bit exp_cyc, exp_fd;
    case (mode)
      0:       ack_i = 1'b1;
      1:       ack_i = (cyc_no % 3 == 2);
      default: ack_i = 1'($urandom_range(0, 1));
    endcase
    cyc_no++;
    #1;
    exp_cyc = !idle && (gap == 0);
    check_val("cyc", 32'(cyc), 32'(exp_cyc));
    check_val("stb", 32'(stb), 32'(exp_cyc));
    if (exp_cyc) begin
      check_val("adr", adr, BASE + 32'(2 * n));
      check_val("dat", 32'(dat), 32'(ref_pixel(n)));
    end
    exp_fd = exp_cyc && ack_i && (n == FRAME - 1);
    check_val("frame_done", 32'(frame_done_o), 32'(exp_fd));
    if (frame_done_o) fd_count++;
    if (idle) begin
      if (enable_i) idle = 1'b0;
    end else if (gap > 0) begin
      gap--;
    end else if (ack_i) begin
      tacks++;
      if (n == FRAME - 1) begin
        n = 0;
        tacks = 0;
        if (enable_i) gap = PAUSE; else idle = 1'b1;
      end else begin
        n++;
        if (tacks == BURST) begin
          tacks = 0;
          gap = PAUSE;
        end
      end
    end
  endtask

  task automatic cycle(input int mode);
    @(negedge clk);
    step(mode);
  endtask

  task automatic do_reset(input int mode);
    @(negedge clk);
    rst = 1'b1;
    ack_i = 1'b0;
    #1;
    check_val("rst_cyc", 32'(cyc), 32'd0);
    check_val("rst_adr", adr, BASE);
    check_val("rst_dat", 32'(dat), 32'hFFFF);
    check_val("rst_fd", 32'(frame_done_o), 32'd0);
    check_val("const_we_sel", {26'd0, we, sel, cti}, {26'd0, 1'b1, 2'b11, 3'b000});
    check_val("const_bte", 32'(bte), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(mode);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; enable_i = 1'b1; ack_i = 1'b0; cyc_no = 0;
    model_reset();

    // Continuous ack: burst/pause timing and one full frame
    do_reset(0);
    repeat (45) cycle(0);
    check_val("fd_count_t1", 32'(fd_count), 32'd1);

    // ack every third cycle: adr/dat must hold while waiting
    do_reset(1);
    repeat (150) cycle(1);
    check_val("fd_count_t3", 32'(fd_count), 32'd1);

    // Random ack, enable dropped at write 10: frame still completes then idles
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      if (n == 10) enable_i = 1'b0;
      cycle(2);
    end
    check_val("fd_count_t4", 32'(fd_count), 32'd1);
    check_val("idle_t4", 32'(idle), 32'd1);

    // Async reset while a write to 0x116 is outstanding
    enable_i = 1'b1;
    do_reset(0);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle(0);
      if (n == 11 && !idle && gap == 0) begin
        hit = 1'b1;
        break;
      end
    end
    check_val("reach_116", 32'(hit), 32'd1);
    @(negedge clk);
    ack_i = 1'b0;
    #1;
    check_val("pre_rst_cyc", 32'(cyc), 32'd1);
    check_val("pre_rst_adr", adr, 32'h116);
    #1 rst = 1'b1;
    #1;
    check_val("async_rst_cyc", 32'(cyc), 32'd0);
    check_val("async_rst_adr", adr, BASE);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0);
    repeat (20) cycle(2);

    // Two back-to-back frames with enable held
    do_reset(0);
    repeat (90) cycle(0);
    check_val("fd_count_t6", 32'(fd_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
